// File: rtl/idac_sar_ctrl.sv
// Successive-approximation controller for an N-bit R2R current DAC.
// Holds each trial code for SETTLE_CYC cycles, then weighs the synchronised comparator decision.
module idac_sar_ctrl #(
  parameter int N          = 8,
  parameter int SETTLE_CYC = 4,
  parameter int CMP_INV    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         cmp,
  output logic [N-1:0] ib,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int  KW  = (N > 1) ? $clog2(N) : 1;
  localparam int  CW  = $clog2(SETTLE_CYC) + 1;
  localparam logic INV = (CMP_INV != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [CW-1:0] cnt;
  logic          cmp_m;
  logic          cmp_s;
  logic          hi;
  logic [N-1:0]  trial;

  // The comparator output is asynchronous to clk, so it is resynchronised before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_m <= 1'b0;
      cmp_s <= 1'b0;
    end else begin
      cmp_m <= cmp;
      cmp_s <= cmp_m;
    end
  end

  assign hi = cmp_s ^ INV;

  // Current code with the bit under test dropped when the IDAC current is too high.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    trial = ib;
    if (hi) trial[k] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ib     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      k      <= KW'(N - 1);
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ib <= '0;
          if (start) begin
            k     <= KW'(N - 1);
            ib    <= N'(1) << (N - 1);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            cnt   <= '0;
            state <= DECIDE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DECIDE: begin
          if (k != '0) begin
            ib    <= trial | (N'(1) << (k - KW'(1)));
            k     <= k - KW'(1);
            state <= SETTLE;
          end else begin
            result <= trial;
            done   <= 1'b1;
            ib     <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idac_sar_ctrl.sv
// Directed bench for idac_sar_ctrl: default, inverted-comparator and short-settle instances.
// The comparator model compares the driven code with a target input on each falling edge.
module tb_idac_sar_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start  [3];
  logic       cmp    [3];
  logic [7:0] ib     [3];
  logic       busy   [3];
  logic       done   [3];
  logic [7:0] result [3];

  // 0: cmp = ib > vin, 1: stuck high, 2: stuck low, 3: cmp = !(ib > vin)
  int         mode [3];
  logic [7:0] vin  [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] trials_5a [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

  idac_sar_ctrl #(.N(8), .SETTLE_CYC(4), .CMP_INV(0)) u_def (
    .clk(clk), .reset(reset), .start(start[0]), .cmp(cmp[0]),
    .ib(ib[0]), .busy(busy[0]), .done(done[0]), .result(result[0])
  );

  idac_sar_ctrl #(.N(8), .SETTLE_CYC(4), .CMP_INV(1)) u_inv (
    .clk(clk), .reset(reset), .start(start[1]), .cmp(cmp[1]),
    .ib(ib[1]), .busy(busy[1]), .done(done[1]), .result(result[1])
  );

  idac_sar_ctrl #(.N(8), .SETTLE_CYC(2), .CMP_INV(0)) u_s2 (
    .clk(clk), .reset(reset), .start(start[2]), .cmp(cmp[2]),
    .ib(ib[2]), .busy(busy[2]), .done(done[2]), .result(result[2])
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      case (mode[i])
        1:       cmp[i] = 1'b1;
        2:       cmp[i] = 1'b0;
        3:       cmp[i] = !(ib[i] > vin[i]);
        default: cmp[i] = (ib[i] > vin[i]);
      endcase
    end
  end

  // Pulse start for one edge; returns on the falling edge after the sampling edge.
  task automatic do_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Follows a conversion from the falling edge after start was sampled up to its done cycle.
  task automatic track(input int d, input int lat, input logic [7:0] exp,
                       input bit chk_trials, input bit poke_start, input bit restart);
    int hold;
    hold = lat / 8;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      if (poke_start) start[d] = (k == 7 || k == 8 || k == 23);
      if (k < lat) begin
        n_checks++;
        if (busy[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_during[%0d] k=%0d: got %b expected 1", d, k, busy[d]);
        end
        n_checks++;
        if (done[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL done_early[%0d] k=%0d: got %b expected 0", d, k, done[d]);
        end
        if (chk_trials) begin
          n_checks++;
          if (ib[d] !== trials_5a[k / hold]) begin
            n_fail++;
            $display("FAIL ib_trial[%0d] k=%0d: got %h expected %h", d, k, ib[d], trials_5a[k / hold]);
          end
        end
      end else begin
        n_checks++;
        if (done[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL done_at_lat[%0d] k=%0d: got %b expected 1", d, k, done[d]);
        end
        n_checks++;
        if (result[d] !== exp) begin
          n_fail++;
          $display("FAIL result[%0d]: got %h expected %h", d, result[d], exp);
        end
        n_checks++;
        if (busy[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_on_done[%0d]: got %b expected 0", d, busy[d]);
        end
        n_checks++;
        if (ib[d] !== 8'h00) begin
          n_fail++;
          $display("FAIL ib_on_done[%0d]: got %h expected 00", d, ib[d]);
        end
      end
    end
    if (restart) begin
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      n_checks++;
      if (ib[d] !== 8'h80) begin
        n_fail++;
        $display("FAIL ib_restart[%0d]: got %h expected 80", d, ib[d]);
      end
    end else begin
      @(negedge clk);
      n_checks++;
      if (done[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse_len[%0d]: got %b expected 0", d, done[d]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ib[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_ib[%0d]: got %h expected 00", i, ib[i]);
      end
      n_checks++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got busy=%b done=%b expected 0 0", i, busy[i], done[i]);
      end
      n_checks++;
      if (result[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_result[%0d]: got %h expected 00", i, result[i]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_convert();
    mode[0] = 0;
    vin[0]  = 8'h5A;
    @(negedge clk);
    do_start(0);
    track(0, 40, 8'h5A, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stuck();
    mode[0] = 1;
    @(negedge clk);
    do_start(0);
    track(0, 40, 8'h00, 1'b0, 1'b0, 1'b0);
    mode[0] = 2;
    @(negedge clk);
    do_start(0);
    track(0, 40, 8'hFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    mode[0] = 0;
    vin[0]  = 8'h5A;
    @(negedge clk);
    do_start(0);
    track(0, 40, 8'h5A, 1'b1, 1'b1, 1'b1);
    track(0, 40, 8'h5A, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    mode[0] = 0;
    vin[0]  = 8'h5A;
    @(negedge clk);
    do_start(0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ib[0] !== 8'h00 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got ib=%h busy=%b expected 00 0", ib[0], busy[0]);
    end
    n_checks++;
    if (result[0] !== 8'h00 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_result: got result=%h done=%b expected 00 0", result[0], done[0]);
    end
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %b expected 0", seen_done);
    end
    do_start(0);
    track(0, 40, 8'h5A, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_inverted();
    mode[1] = 3;
    vin[1]  = 8'h5A;
    @(negedge clk);
    do_start(1);
    track(1, 40, 8'h5A, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_short_settle();
    mode[2] = 0;
    vin[2]  = 8'hC3;
    @(negedge clk);
    do_start(2);
    track(2, 24, 8'hC3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      mode[i]  = 0;
      vin[i]   = 8'h00;
    end
    test_reset();
    test_convert();
    test_stuck();
    test_back_to_back();
    test_reset_mid();
    test_inverted();
    test_short_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
